// File: rtl/fpga_input_port_pkg.sv
// Shared miniRISC input-port constants: default widths, debounce length and
// debouncer state encodings.
package fpga_input_port_pkg;

  localparam int unsigned DATA_W_DEF    = 10;
  localparam int unsigned DB_CYCLES_DEF = 16;
  localparam int unsigned CNT_W         = 8;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_WAIT   = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_WAIT   = 2'd3
  } db_state_t;

endpackage

// File: rtl/fpga_input_port_btn_debounce.sv
// Push-button synchronizer plus 4-state debounce FSM; db is the qualified level,
// rise is a one-cycle pulse in the cycle whose closing edge enters HIGH_STABLE.
module btn_debounce
  import fpga_input_port_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic db,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1, s2;
  db_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= LOW_STABLE;
      cnt   <= '0;
    end else begin
      s1    <= btn_in;
      s2    <= s1;
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // rise is Mealy so the capture lands on the same edge that db goes high
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise     = 1'b0;
    case (state)
      LOW_STABLE: begin
        if (s2) begin
          state_nx = RISE_WAIT;
          cnt_nx   = CNT_W'(1);
        end
      end
      RISE_WAIT: begin
        if (!s2) begin
          state_nx = LOW_STABLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = HIGH_STABLE;
          cnt_nx   = '0;
          rise     = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      HIGH_STABLE: begin
        if (!s2) begin
          state_nx = FALL_WAIT;
          cnt_nx   = CNT_W'(1);
        end
      end
      FALL_WAIT: begin
        if (s2) begin
          state_nx = HIGH_STABLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = LOW_STABLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = LOW_STABLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    db = (state == HIGH_STABLE) || (state == FALL_WAIT);
  end

endmodule

// File: rtl/fpga_input_port.sv
// Switch-word input port: captures the synchronized switches on a debounced
// button press and hands the word to the processor with a one-cycle valid.
module fpga_input_port
  import fpga_input_port_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              btn_in,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              pending,
  output logic              overrun
);

  logic [DATA_W-1:0] sw_s1, sw_s2, hold;
  logic              btn_db, btn_rise;
  logic              capture, accept;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .db     (btn_db),
    .rise   (btn_rise)
  );

  // rise can only fire while the debounced level is still low
  always_comb begin
    capture = btn_rise & ~btn_db;
    accept  = rd_req & pending;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_s1    <= '0;
      sw_s2    <= '0;
      hold     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      sw_s1    <= sw_in;
      sw_s2    <= sw_s1;
      rd_valid <= accept;
      if (capture) hold <= sw_s2;
      if (accept)  rd_data <= hold;
      if (capture)     pending <= 1'b1;
      else if (accept) pending <= 1'b0;
      if (capture && pending && !accept) overrun <= 1'b1;
      else if (accept)                   overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fpga_input_port.sv
// Directed bench for fpga_input_port with DB_CYCLES=4; delivered words are
// checked against a queue of expected words filled as presses are driven.
module tb_fpga_input_port;

  localparam int unsigned DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] sw_in;
  logic          btn_in;
  logic          rd_req;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          pending;
  logic          overrun;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  fpga_input_port #(
    .DATA_W    (DW),
    .DB_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .btn_in   (btn_in),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .pending  (pending),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [DW-1:0] word);
    sw_in  = word;
    btn_in = 1'b1;
    repeat (6) tick();
    btn_in = 1'b0;
    repeat (7) tick();
  endtask

  task automatic do_read(input logic exp_pend);
    logic got;
    got    = 1'b0;
    rd_req = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (rd_valid) got = 1'b1;
    end
    check("rd_valid_seen", got, 1);
    check("pend_after_rd", pending, exp_pend);
    tick();
    check("rd_valid_one_cycle", rd_valid, 0);
    rd_req = 1'b0;
    tick();
  endtask

  // scoreboard: every delivered word must match the oldest expected word
  always @(posedge clk) begin
    #1;
    if (rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", 1, 0);
      else                   check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [0:7]    bseq;
    int unsigned n_v;

    rst = 1'b0; sw_in = '0; btn_in = 1'b0; rd_req = 1'b0;
    repeat (2) tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b1;
    tick();

    // clean press: pending on the sixth edge
    sw_in  = 10'h2A5;
    btn_in = 1'b1;
    repeat (5) tick();
    check("lat_pend_e5", pending, 0);
    tick();
    check("lat_pend_e6", pending, 1);
    check("lat_valid_e6", rd_valid, 0);
    exp_q.push_back(10'h2A5);
    btn_in = 1'b0;
    do_read(1'b0);
    repeat (6) tick();
    sw_in = 10'h3C3;
    repeat (4) tick();
    check("sw_noeffect_data", rd_data, 10'h2A5);
    check("sw_noeffect_pend", pending, 0);
    check("sw_noeffect_valid", rd_valid, 0);

    // bouncy press: only the final four highs qualify
    sw_in = 10'h0AA;
    bseq  = 8'b1110_1111;
    for (int i = 0; i < 8; i++) begin
      btn_in = bseq[i];
      tick();
    end
    check("bounce_pend_e8", pending, 0);
    tick();
    check("bounce_pend_e9", pending, 0);
    tick();
    check("bounce_pend_e10", pending, 1);
    exp_q.push_back(10'h0AA);
    do_read(1'b0);
    repeat (6) tick();
    check("bounce_single_capture", pending, 0);
    btn_in = 1'b0;
    repeat (7) tick();

    // overrun: second press overwrites unread word
    press(10'h001);
    check("ovr_first_pend", pending, 1);
    check("ovr_first_flag", overrun, 0);
    press(10'h3FF);
    check("ovr_second_pend", pending, 1);
    check("ovr_second_flag", overrun, 1);
    exp_q.push_back(10'h3FF);
    do_read(1'b0);
    check("ovr_cleared", overrun, 0);

    // request held from reset release, served once pending rises
    rst = 1'b0;
    tick();
    rst    = 1'b1;
    rd_req = 1'b1;
    n_v    = 0;
    repeat (20) begin
      tick();
      if (rd_valid) n_v++;
    end
    check("idle_req_no_valid", n_v, 0);
    sw_in  = 10'h155;
    btn_in = 1'b1;
    repeat (6) tick();
    check("waitreq_pend", pending, 1);
    check("waitreq_valid_early", rd_valid, 0);
    exp_q.push_back(10'h155);
    tick();
    check("waitreq_valid", rd_valid, 1);
    check("waitreq_pend_clr", pending, 0);
    rd_req = 1'b0;
    btn_in = 1'b0;
    repeat (7) tick();

    // capture and read accepted on the same edge
    press(10'h0F0);
    exp_q.push_back(10'h0F0);
    check("same_edge_pre_pend", pending, 1);
    sw_in  = 10'h00F;
    btn_in = 1'b1;
    repeat (5) tick();
    rd_req = 1'b1;
    tick();
    check("same_edge_valid", rd_valid, 1);
    check("same_edge_pend", pending, 1);
    check("same_edge_ovr", overrun, 0);
    exp_q.push_back(10'h00F);
    rd_req = 1'b0;
    tick();
    check("same_edge_valid_drop", rd_valid, 0);
    btn_in = 1'b0;
    repeat (6) tick();
    do_read(1'b0);

    // reset two cycles into RISE_WAIT with state pending
    press(10'h155);
    press(10'h2AA);
    check("pre_rst_ovr", overrun, 1);
    btn_in = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    check("midrst_rd_data", rd_data, 0);
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_pending", pending, 0);
    check("midrst_overrun", overrun, 0);
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (12) tick();
    check("midrst_no_capture", pending, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpga_input_port.md
FPGA_INPUT_PORT -- requirements
Module: fpga_input_port

Interface
REQ-001 Parameter DATA_W, default 10: width of the switch input word.
REQ-002 Parameter DB_CYCLES, default 16: consecutive stable cycles required to accept a button level change; legal range 2..255.
REQ-003 Port clk, input, 1: single system clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-low.
REQ-005 Port sw_in, input, DATA_W: asynchronous slide-switch word.
REQ-006 Port btn_in, input, 1: asynchronous, bouncy "enter" push-button; active-high.
REQ-007 Port rd_req, input, 1: processor read request for the input instruction; held high until rd_valid is seen.
REQ-008 Port rd_data, output, DATA_W: delivered word; registered.
REQ-009 Port rd_valid, output, 1: one-cycle pulse; rd_data is valid in the same cycle.
REQ-010 Port pending, output, 1: a captured word is waiting to be read.
REQ-011 Port overrun, output, 1: sticky flag; an unread word was overwritten.

Function
REQ-012 sw_in and btn_in SHALL each pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-013 The debouncer SHALL be a 4-state FSM: LOW_STABLE, RISE_WAIT, HIGH_STABLE, FALL_WAIT; the debounced level db is 1 in HIGH_STABLE and FALL_WAIT.
REQ-014 From LOW_STABLE, btn s2=1 SHALL move to RISE_WAIT with the counter at 1. In RISE_WAIT, s2=1 increments the counter; s2=0 returns to LOW_STABLE with the counter cleared.
REQ-015 RISE_WAIT SHALL move to HIGH_STABLE on the edge where s2=1 and the counter equals DB_CYCLES-1, so db rises on the DB_CYCLES-th consecutive high s2 sample. FALL_WAIT is symmetric toward LOW_STABLE.
REQ-016 On the edge entering HIGH_STABLE from RISE_WAIT, the block SHALL load the holding register from the synchronized sw_in (s2) and set pending=1. The falling transition SHALL capture nothing.
REQ-017 Latency: with btn_in high and stable before edge E1, pending SHALL rise at edge E(2+DB_CYCLES).
REQ-018 Read handshake: if rd_req=1 and pending=1 at edge N, then at edge N+1 rd_data SHALL equal the held word, rd_valid=1 and pending=0.
REQ-019 rd_valid SHALL be high for exactly one cycle per delivered word, and rd_data SHALL hold its value until the next delivery.
REQ-020 rd_req=1 with pending=0 SHALL produce no rd_valid. The request waits and is served on the first edge at which pending=1, following REQ-018 timing.
REQ-021 If rd_req stays high in the cycle after rd_valid, no second rd_valid SHALL be generated unless a new capture has set pending.
REQ-022 If a capture and a read are accepted on the same edge, rd_data SHALL receive the old held word, the holding register SHALL receive the new word, and pending SHALL remain 1.
REQ-023 If a capture occurs while pending=1 and no read is accepted on that edge, the held word SHALL be overwritten and overrun set to 1.
REQ-024 overrun SHALL clear on the edge that asserts rd_valid, unless an overwrite occurs on that same edge.
REQ-025 sw_in changes while no capture occurs SHALL have no visible effect on any output.

Reset
REQ-026 While rst=0 at a clock edge, the following SHALL be cleared on that edge: rd_data=0, rd_valid=0, pending=0, overrun=0, FSM=LOW_STABLE, counter=0, synchronizer flops=0, holding register=0.
REQ-027 Reset asserted mid-debounce or mid-handshake SHALL discard all in-flight state with no rd_valid pulse. After release, a button already held high SHALL be treated as a new press (full DB_CYCLES qualification).

Structure
REQ-028 DATA_W, DB_CYCLES defaults and the FSM state encodings SHALL live in the shared miniRISC constants include file.
REQ-029 The synchronizer plus debounce FSM SHALL be one sub-module, btn_debounce, exposing db and a one-cycle rise pulse.
REQ-030 The counter width SHALL be 8 bits.

Verification (DB_CYCLES=4)
REQ-031 sw_in=10'h2A5 with a clean btn_in press -> pending=1 at edge E6; then rd_req -> rd_valid one cycle later with rd_data=10'h2A5, pending=0.
REQ-032 btn_in bouncing 1,1,1,0,1,1,1,1 (one value per cycle) -> no capture until the last four highs complete; exactly one capture results.
REQ-033 Two presses with sw_in=10'h001 then 10'h3FF and no read -> overrun=1, pending=1; read delivers 10'h3FF and clears overrun.
REQ-034 rd_req raised at reset release with no press, held for 20 cycles, then a press with sw_in=10'h155 -> rd_valid at the edge after pending rises, rd_data=10'h155.
REQ-035 Capture and rd_req on the same edge with held word 10'h0F0 and new word 10'h00F -> rd_data=10'h0F0, pending remains 1, and the next read returns 10'h00F.
REQ-036 rst=0 asserted two cycles into RISE_WAIT -> all outputs read 0 on the reset edge and no capture follows from that press.
